// File: rtl/boot_uart_pkg.sv
// rtl/boot_uart_pkg.sv - shared offsets, status bits and FSM states for the boot UART receiver
package boot_uart_pkg;

  localparam logic [31:0] OFS_DATA   = 32'h0;
  localparam logic [31:0] OFS_STATUS = 32'h8;

  localparam int ST_READY = 2;
  localparam int ST_OVR   = 1;
  localparam int ST_FERR  = 0;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  // Below four clocks per bit the half-bit start check collapses.
  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    int c;
    c = clk_freq / baud;
    return (c < 4) ? 4 : c;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 deserialiser: two-flop synchroniser and bit-timing FSM
module uart_rx_core
  import boot_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  logic             r_sync1;
  logic             r_sync2;
  rx_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_wait_high;
  logic             r_byte_valid;
  logic             r_frame_err;

  assign o_byte_valid = r_byte_valid;
  assign o_byte_data  = r_shift;
  assign o_frame_err  = r_frame_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_bit        <= 3'd0;
      r_shift      <= 8'h00;
      r_wait_high  <= 1'b0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_sync1      <= i_rx;
      r_sync2      <= r_sync1;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          // After a framing error the line must be seen high before re-arming.
          if (r_sync2) begin
            r_wait_high <= 1'b0;
          end else if (!r_wait_high) begin
            r_state <= START;
          end
        end
        START: begin
          if (r_cnt == CNT_HALF) begin
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_state <= r_sync2 ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == CNT_FULL) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};
            if (r_bit == 3'd7) begin
              r_state <= STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_cnt == CNT_FULL) begin
            r_cnt   <= '0;
            r_state <= IDLE;
            if (r_sync2) begin
              r_byte_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
              r_wait_high <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/boot_uart_rx.sv
// rtl/boot_uart_rx.sv - memory-mapped boot UART receiver: holding byte, status flags, read decode
module boot_uart_rx
  import boot_uart_pkg::*;
#(
  parameter int          CLK_FREQ  = 50000000,
  parameter int          BAUD      = 115200,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF0120
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iRX,
  input  logic [31:0] iAddress,
  input  logic        iReadEnable,
  output logic [31:0] oReadData,
  output logic        oRxReady
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);

  logic       w_byte_valid;
  logic [7:0] w_byte_data;
  logic       w_frame_err;
  logic       w_sel_data;
  logic       w_sel_status;
  logic       w_clr;

  logic [7:0] r_hold;
  logic       r_ready;
  logic       r_ovr;
  logic       r_ferr;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .i_clk       (iCLK),
    .i_rst_n     (iRST_n),
    .i_rx        (iRX),
    .o_byte_valid(w_byte_valid),
    .o_byte_data (w_byte_data),
    .o_frame_err (w_frame_err)
  );

  assign w_sel_data   = (iAddress == BASE_ADDR + OFS_DATA);
  assign w_sel_status = (iAddress == BASE_ADDR + OFS_STATUS);
  assign w_clr        = iReadEnable & w_sel_data;
  assign oRxReady     = r_ready;

  always_comb begin
    oReadData = 32'h0;
    if (w_sel_data) begin
      oReadData = {24'h0, r_hold};
    end else if (w_sel_status) begin
      oReadData[ST_READY] = r_ready;
      oReadData[ST_OVR]   = r_ovr;
      oReadData[ST_FERR]  = r_ferr;
    end
  end

  // A new byte beats a same-cycle data read: READY stays set and no overrun is flagged.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_hold  <= 8'h00;
      r_ready <= 1'b0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      if (w_clr) begin
        r_ready <= 1'b0;
        r_ovr   <= 1'b0;
        r_ferr  <= 1'b0;
      end
      if (w_byte_valid) begin
        r_hold  <= w_byte_data;
        r_ready <= 1'b1;
        if (r_ready && !w_clr) begin
          r_ovr <= 1'b1;
        end
      end
      if (w_frame_err) begin
        r_ferr <= 1'b1;
      end
    end
  end

endmodule
